// File: rtl/result_gather_ctrl.sv
// ----------------------------------------------------------------------------
// result_gather_ctrl
//
// Reads out NUM_CH result channels one after another (channel 0 first) and
// packs their IN_W-bit words into OUT_W-bit beats on one top-level read
// stream. The word count of every channel is checked, and valid pulses on
// non-selected channels are flagged. Either fault shows up as a one-cycle
// top_rd_err pulse that coincides with the final beat (top_rd_eop).
//
// Optional feature (compile-time macro RD_TIMEOUT_EN):
//   If defined, a COLLECT phase with TIMEOUT_CYC consecutive cycles and no
//   selected word aborts the transfer. The pending partial beat, or an
//   all-zero beat, is emitted with vld, eop and err set, and no further
//   channel is started. If undefined, the block waits for rd_eop
//   indefinitely.
//
// Ports:
//   clk          clock
//   rst          synchronous, active-high reset
//   top_rd_sop   start-of-read request pulse (ignored while busy)
//   top_rd_eop   last output beat of the transfer
//   top_rd_vld   output beat valid
//   top_rd_data  packed output beat; holds its value while vld is low
//   top_rd_err   transfer error pulse, coincides with top_rd_eop
//   top_rd_busy  transfer in progress
//   rd_sop       per-channel start pulse, one-hot, one cycle
//   rd_eop       per-channel end, coincides with that channel's last rd_vld
//   rd_vld       per-channel word valid
//   rd_data      channel k occupies bits [k*IN_W +: IN_W]
// ----------------------------------------------------------------------------
module result_gather_ctrl #(
    parameter int NUM_CH       = 8,
    parameter int IN_W         = 16,
    parameter int OUT_W        = 32,
    parameter int BEATS_PER_CH = 8,
    parameter int TIMEOUT_CYC  = 256
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   top_rd_sop,
    output logic                   top_rd_eop,
    output logic                   top_rd_vld,
    output logic [OUT_W-1:0]       top_rd_data,
    output logic                   top_rd_err,
    output logic                   top_rd_busy,
    output logic [NUM_CH-1:0]      rd_sop,
    input  logic [NUM_CH-1:0]      rd_eop,
    input  logic [NUM_CH-1:0]      rd_vld,
    input  logic [NUM_CH*IN_W-1:0] rd_data
);

    localparam int PACK  = OUT_W / IN_W;
    localparam int SEL_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    localparam int IDX_W = (PACK > 1) ? $clog2(PACK) : 1;
    localparam int CNT_W = $clog2(BEATS_PER_CH + 1) + 1;

    if ((OUT_W % IN_W) != 0 || TIMEOUT_CYC < 1) begin : g_param_check
        $error("result_gather_ctrl: OUT_W must be a multiple of IN_W and TIMEOUT_CYC >= 1");
    end

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        START   = 2'd1,
        COLLECT = 2'd2,
        FLUSH   = 2'd3
    } state_t;

    state_t state, state_nxt;
    logic [SEL_W-1:0] sel, sel_nxt;

    // Selected-channel input stage.
    logic            in_vld_q;
    logic            in_eop_q;
    logic [IN_W-1:0] in_data_q;

    // Pack register, word index within the current beat, per-channel count.
    logic [PACK-1:0][IN_W-1:0] pack;
    logic [PACK-1:0][IN_W-1:0] pack_ins;
    logic [IDX_W-1:0]          pack_idx;
    logic [CNT_W-1:0]          word_cnt;
    logic [CNT_W-1:0]          cnt_eff;

    logic mismatch_q;
    logic stray_q;

    logic [NUM_CH-1:0] sel_mask;
    logic              capture_en;
    logic              beat_done;
    logic              ch_eop;
    logic              ch_bad;
    logic              last_ch;
    logic              stray_hit;
    logic              timeout_hit;
    logic              timed_out;

    // Next values of the registered outputs.
    logic              vld_d;
    logic              eop_d;
    logic              err_d;
    logic              busy_d;
    logic [OUT_W-1:0]  data_d;
    logic [NUM_CH-1:0] rd_sop_d;

    // ------------------------------------------------------------------------
    // Derived per-cycle conditions
    // ------------------------------------------------------------------------
    assign sel_mask  = {{(NUM_CH-1){1'b0}}, 1'b1} << sel;
    assign last_ch   = (sel == SEL_W'(NUM_CH - 1));
    assign ch_eop    = (state == COLLECT) && in_eop_q;
    assign beat_done = in_vld_q && (pack_idx == IDX_W'(PACK - 1));
    // Any valid outside the selected channel during a transfer is a fault.
    assign stray_hit = (state != IDLE) && |(rd_vld & ~sel_mask);
    // Capture stops once the channel closes (or times out), so a registered
    // word is only ever processed while still in COLLECT.
    assign capture_en = (state == COLLECT) && !ch_eop && !timeout_hit;

    // Count including the word being processed this cycle; saturates.
    assign cnt_eff = (in_vld_q && (word_cnt != {CNT_W{1'b1}})) ? word_cnt + CNT_W'(1) : word_cnt;
    assign ch_bad  = ch_eop && (cnt_eff != CNT_W'(BEATS_PER_CH));

    always_comb begin
        pack_ins           = pack;
        pack_ins[pack_idx] = in_data_q;
    end

`ifdef RD_TIMEOUT_EN
    localparam int TO_W = $clog2(TIMEOUT_CYC + 1);
    logic [TO_W-1:0] idle_cnt;
    logic            timed_out_q;

    assign timeout_hit = (state == COLLECT) && !in_vld_q && !in_eop_q &&
                         (idle_cnt == TO_W'(TIMEOUT_CYC - 1));
    assign timed_out   = timed_out_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            idle_cnt    <= '0;
            timed_out_q <= 1'b0;
        end else begin
            if (state == COLLECT && !in_vld_q) begin
                idle_cnt <= idle_cnt + TO_W'(1);
            end else begin
                idle_cnt <= '0;
            end
            if (state == IDLE) begin
                timed_out_q <= 1'b0;
            end else if (timeout_hit) begin
                timed_out_q <= 1'b1;
            end
        end
    end
`else
    assign timeout_hit = 1'b0;
    assign timed_out   = 1'b0;
`endif

    // ------------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------------
    // NOTE: every clocked block uses non-blocking assignments so all registers
    // update from the same pre-edge values, independent of process order.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            sel   <= '0;
        end else begin
            state <= state_nxt;
            sel   <= sel_nxt;
        end
    end

    // ------------------------------------------------------------------------
    // FSM: next-state logic
    // ------------------------------------------------------------------------
    // NOTE: defaults assigned first so every path drives every output of the
    // combinational block; a missing branch would otherwise infer a latch.
    always_comb begin
        state_nxt = state;
        sel_nxt   = sel;
        unique case (state)
            IDLE: begin
                // busy also covers the cycle after a FLUSH-emitted eop.
                if (top_rd_sop && !top_rd_busy) begin
                    state_nxt = START;
                    sel_nxt   = '0;
                end
            end
            START: begin
                state_nxt = COLLECT;
            end
            COLLECT: begin
                if (timeout_hit) begin
                    state_nxt = FLUSH;
                end else if (ch_eop) begin
                    if (last_ch) begin
                        state_nxt = FLUSH;
                    end else begin
                        state_nxt = START;
                        sel_nxt   = sel + SEL_W'(1);
                    end
                end
            end
            FLUSH: begin
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------------
    // FSM: output logic. Outputs are registered, so their next values are
    // derived from the next state; rd_sop is therefore high during START.
    // ------------------------------------------------------------------------
    always_comb begin
        rd_sop_d = '0;
        vld_d    = 1'b0;
        eop_d    = 1'b0;
        err_d    = 1'b0;
        data_d   = top_rd_data;

        if (state_nxt == START) begin
            rd_sop_d[sel_nxt] = 1'b1;
        end

        if (state == COLLECT && beat_done) begin
            vld_d  = 1'b1;
            data_d = pack_ins;
            // The last channel's last word fills the beat exactly: this is the
            // final beat, so eop/err go out here and FLUSH stays silent.
            if (ch_eop && last_ch) begin
                eop_d = 1'b1;
                err_d = mismatch_q | ch_bad | stray_q | stray_hit;
            end
        end

        // Partial beat (upper words already zero) or all-zero timeout beat.
        if (state == FLUSH && (pack_idx != '0 || timed_out)) begin
            vld_d  = 1'b1;
            eop_d  = 1'b1;
            data_d = pack;
            err_d  = mismatch_q | stray_q | stray_hit | timed_out;
        end

        busy_d = (state_nxt != IDLE) || eop_d;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            top_rd_vld  <= 1'b0;
            top_rd_eop  <= 1'b0;
            top_rd_err  <= 1'b0;
            top_rd_busy <= 1'b0;
            top_rd_data <= '0;
            rd_sop      <= '0;
        end else begin
            top_rd_vld  <= vld_d;
            top_rd_eop  <= eop_d;
            top_rd_err  <= err_d;
            top_rd_busy <= busy_d;
            top_rd_data <= data_d;
            rd_sop      <= rd_sop_d;
        end
    end

    // ------------------------------------------------------------------------
    // Input stage: only the selected channel is sampled.
    // ------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            in_vld_q  <= 1'b0;
            in_eop_q  <= 1'b0;
            in_data_q <= '0;
        end else begin
            in_vld_q <= capture_en & rd_vld[sel];
            in_eop_q <= capture_en & rd_eop[sel];
            if (capture_en && rd_vld[sel]) begin
                in_data_q <= rd_data[int'(sel)*IN_W +: IN_W];
            end
        end
    end

    // ------------------------------------------------------------------------
    // Packing and counting. The pack index runs continuously across channel
    // boundaries; it is only cleared at the start and end of a transfer.
    // ------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            pack       <= '0;
            pack_idx   <= '0;
            word_cnt   <= '0;
            mismatch_q <= 1'b0;
            stray_q    <= 1'b0;
        end else begin
            if (state == IDLE || state == FLUSH) begin
                pack     <= '0;
                pack_idx <= '0;
            end else if (in_vld_q) begin
                if (beat_done) begin
                    pack     <= '0;
                    pack_idx <= '0;
                end else begin
                    pack     <= pack_ins;
                    pack_idx <= pack_idx + IDX_W'(1);
                end
            end

            if (state == START) begin
                word_cnt <= '0;
            end else begin
                word_cnt <= cnt_eff;
            end

            if (state == IDLE) begin
                mismatch_q <= 1'b0;
                stray_q    <= 1'b0;
            end else begin
                if (ch_bad) begin
                    mismatch_q <= 1'b1;
                end
                if (stray_hit) begin
                    stray_q <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_result_gather_ctrl.sv
// ----------------------------------------------------------------------------
// tb_result_gather_ctrl
//
// Drives result_gather_ctrl as a set of well-behaved channel buffers plus
// deliberate faults (short/long bursts, stray valids, extra top_rd_sop, reset
// mid-transfer and, with RD_TIMEOUT_EN, a stalled channel). Every word sent
// is recorded; the expected beat stream is rebuilt from that list by plain
// chunking into groups of PACK words.
// ----------------------------------------------------------------------------
module tb_result_gather_ctrl;

    localparam int NUM_CH = 8;
    localparam int IN_W   = 16;
    localparam int OUT_W  = 32;
    localparam int BPC    = 8;
    localparam int PACK   = OUT_W / IN_W;

    logic                   clk = 1'b0;
    logic                   rst;
    logic                   top_rd_sop;
    logic                   top_rd_eop;
    logic                   top_rd_vld;
    logic [OUT_W-1:0]       top_rd_data;
    logic                   top_rd_err;
    logic                   top_rd_busy;
    logic [NUM_CH-1:0]      rd_sop;
    logic [NUM_CH-1:0]      rd_eop;
    logic [NUM_CH-1:0]      rd_vld;
    logic [NUM_CH*IN_W-1:0] rd_data;

    result_gather_ctrl #(
        .NUM_CH      (NUM_CH),
        .IN_W        (IN_W),
        .OUT_W       (OUT_W),
        .BEATS_PER_CH(BPC),
        .TIMEOUT_CYC (16)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .top_rd_sop (top_rd_sop),
        .top_rd_eop (top_rd_eop),
        .top_rd_vld (top_rd_vld),
        .top_rd_data(top_rd_data),
        .top_rd_err (top_rd_err),
        .top_rd_busy(top_rd_busy),
        .rd_sop     (rd_sop),
        .rd_eop     (rd_eop),
        .rd_vld     (rd_vld),
        .rd_data    (rd_data)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [OUT_W-1:0] data;
        logic             eop;
        logic             err;
    } beat_t;

    // One transfer's stimulus and hand-derived expectations.
    // exp_beats < 0 means "take beat count and err from the model".
    typedef struct {
        int short_ch;
        int ch_len;
        int stray_ch;
        int stray_tgt;
        int dup_ch;
        int gap;
        int stall_ch;
        int exp_beats;
        bit exp_err;
    } vec_t;

    beat_t            got_q[$];
    beat_t            exp_q[$];
    logic [IN_W-1:0]  sent_q[$];
    int               ch_cnt[NUM_CH];
    bit               stray_done;
    int               eop_cyc;
    int               orphan_cnt;
    logic [NUM_CH-1:0] sop_seen;
    vec_t             vecs[$];

    // Output monitor, sampled away from the active edge.
    always @(negedge clk) begin
        beat_t b;
        if (top_rd_vld) begin
            b.data = top_rd_data;
            b.eop  = top_rd_eop;
            b.err  = top_rd_err;
            got_q.push_back(b);
            if (top_rd_eop) eop_cyc = cyc;
        end
        if ((top_rd_eop || top_rd_err) && !top_rd_vld) orphan_cnt++;
        sop_seen = sop_seen | rd_sop;
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic vec_t mk(input int short_ch, input int ch_len, input int stray_ch,
                                input int stray_tgt, input int dup_ch, input int gap,
                                input int stall_ch, input int exp_beats, input bit exp_err);
        vec_t v;
        v.short_ch  = short_ch;
        v.ch_len    = ch_len;
        v.stray_ch  = stray_ch;
        v.stray_tgt = stray_tgt;
        v.dup_ch    = dup_ch;
        v.gap       = gap;
        v.stall_ch  = stall_ch;
        v.exp_beats = exp_beats;
        v.exp_err   = exp_err;
        return v;
    endfunction

    // Reference: cut the sent word list into PACK-word beats, LSB word first,
    // zero-padding the last; eop on the last beat. A timed-out transfer with
    // no pending words yields an extra all-zero beat.
    task automatic build_expect(input bit stalled);
        beat_t b;
        exp_q.delete();
        for (int j = 0; j < sent_q.size(); j += PACK) begin
            b.data = '0;
            for (int p = 0; p < PACK && j + p < sent_q.size(); p++)
                b.data[p*IN_W +: IN_W] = sent_q[j+p];
            b.eop = (j + PACK >= sent_q.size());
            b.err = 1'b0;
            exp_q.push_back(b);
        end
        if (stalled && (sent_q.size() % PACK) == 0) begin
            if (exp_q.size() > 0) exp_q[exp_q.size()-1].eop = 1'b0;
            b.data = '0;
            b.eop  = 1'b1;
            b.err  = 1'b0;
            exp_q.push_back(b);
        end
    endtask

    task automatic clear_inputs();
        top_rd_sop = 1'b0;
        rd_vld     = '0;
        rd_eop     = '0;
    endtask

    task automatic wait_sop(input int k, output int waited);
        waited = -1;
        for (int n = 1; n <= 64; n++) begin
            @(negedge clk);
            clear_inputs();
            if (rd_sop[k]) begin
                waited = n;
                break;
            end
        end
    endtask

    task automatic check_quiet_outputs(input string tag);
        check({tag, " vld"},    top_rd_vld,  0);
        check({tag, " eop"},    top_rd_eop,  0);
        check({tag, " err"},    top_rd_err,  0);
        check({tag, " busy"},   top_rd_busy, 0);
        check({tag, " rd_sop"}, rd_sop,      0);
        check({tag, " data"},   top_rd_data, 0);
    endtask

    task automatic run_transfer(input vec_t v, input bit rnd, input int abort_ch, input string tag);
        int              waited;
        int              len;
        int              n_eop;
        int              nb;
        bit              e_err;
        bit              stalled;
        logic [IN_W-1:0] w;

        got_q.delete();
        sent_q.delete();
        foreach (ch_cnt[k]) ch_cnt[k] = 0;
        sop_seen   = '0;
        orphan_cnt = 0;
        eop_cyc    = -1;
        stray_done = 0;
        stalled    = (v.stall_ch >= 0);

        @(negedge clk);
        top_rd_sop = 1'b1;
        for (int k = 0; k < NUM_CH; k++) begin
            wait_sop(k, waited);
            if (waited < 0) begin
                check($sformatf("%s ch%0d rd_sop wait", tag, k), 0, 1);
                return;
            end
            // First channel: one cycle after the request; later: 2 after eop.
            check($sformatf("%s ch%0d sop spacing", tag, k), waited, (k == 0) ? 1 : 2);
            @(negedge clk);
            clear_inputs();
            check($sformatf("%s ch%0d sop width", tag, k), rd_sop, 0);

            len = (k == v.short_ch) ? v.ch_len : BPC;
            if (k == v.stall_ch) len = 3;
            for (int i = 0; i < len; i++) begin
                for (int g = $urandom_range(v.gap, 0); g > 0; g--) begin
                    @(negedge clk);
                    clear_inputs();
                end
                @(negedge clk);
                clear_inputs();
                w = rnd ? IN_W'($urandom) : IN_W'(k*16 + i);
                rd_vld[k]                = 1'b1;
                rd_data[k*IN_W +: IN_W]  = w;
                rd_eop[k]                = (i == len - 1) && (k != v.stall_ch);
                sent_q.push_back(w);
                ch_cnt[k]++;
                if (k == v.stray_ch && i == 2) begin
                    rd_vld[v.stray_tgt]                     = 1'b1;
                    rd_data[v.stray_tgt*IN_W +: IN_W]       = IN_W'(16'hdead);
                    stray_done                              = 1;
                end
                if (k == v.dup_ch && i == 1) top_rd_sop = 1'b1;
                if (k == abort_ch && i == 2) begin
                    clear_inputs();
                    rst = 1'b1;
                    @(negedge clk);
                    check_quiet_outputs({tag, " abort"});
                    rst = 1'b0;
                    n_eop = 0;
                    foreach (got_q[j]) if (got_q[j].eop) n_eop++;
                    check({tag, " abort no eop"}, n_eop, 0);
                    return;
                end
            end
            if (k == v.stall_ch) break;
        end

        @(negedge clk);
        clear_inputs();
        waited = -1;
        for (int n = 0; n < 100; n++) begin
            if (!top_rd_busy) begin
                waited = n;
                break;
            end
            @(negedge clk);
        end
        if (waited < 0) begin
            check({tag, " busy drop wait"}, 0, 1);
            return;
        end
        check({tag, " busy drop after eop"}, cyc - eop_cyc, 1);
        check({tag, " eop/err outside vld"}, orphan_cnt, 0);

        build_expect(stalled);
        e_err = stray_done || stalled;
        foreach (ch_cnt[k]) if (ch_cnt[k] != BPC) e_err = 1;
        nb = exp_q.size();
        if (v.exp_beats >= 0) begin
            nb    = v.exp_beats;
            e_err = v.exp_err;
        end
        check({tag, " beat count"}, got_q.size(), nb);
        for (int j = 0; j < got_q.size() && j < exp_q.size(); j++) begin
            check($sformatf("%s beat%0d data", tag, j), got_q[j].data, exp_q[j].data);
            check($sformatf("%s beat%0d eop", tag, j), got_q[j].eop, exp_q[j].eop);
            check($sformatf("%s beat%0d err", tag, j), got_q[j].err,
                  (j == got_q.size() - 1) ? e_err : 1'b0);
        end
        if (stalled) check({tag, " no later rd_sop"}, sop_seen[NUM_CH-1], 0);

        // A stale request must not restart the block on its own.
        repeat (3) @(negedge clk);
        check({tag, " stays idle"}, top_rd_busy, 0);
    endtask

    initial begin
        vec_t v;

        rst        = 1'b1;
        top_rd_sop = 1'b0;
        rd_vld     = '0;
        rd_eop     = '0;
        rd_data    = '0;
        repeat (3) @(negedge clk);
        check_quiet_outputs("reset");
        rst = 1'b0;

        //        short len stray tgt dup gap stall beats err
        vecs.push_back(mk(-1, 8, -1, 0, -1, 0, -1, 32, 0));  // nominal
        vecs.push_back(mk( 3, 7, -1, 0, -1, 0, -1, 32, 1));  // short ch3, partial end
        vecs.push_back(mk(-1, 8,  2, 5, -1, 1, -1, 32, 1));  // stray vld[5] on sel=2
        vecs.push_back(mk(-1, 8, -1, 0,  1, 0, -1, 32, 0));  // sop while busy ignored
        vecs.push_back(mk(-1, 8, -1, 0, -1, 0, -1, 32, 0));  // back-to-back clean
        vecs.push_back(mk( 1, 9, -1, 0, -1, 2, -1, 33, 1));  // long ch1
        vecs.push_back(mk( 7, 6, -1, 0, -1, 1, -1, 31, 1));  // short last ch, full end
        vecs.push_back(mk( 0, 5, -1, 0, -1, 2, -1, 31, 1));  // short first ch
`ifdef RD_TIMEOUT_EN
        vecs.push_back(mk(-1, 8, -1, 0, -1, 0,  6, 26, 1));  // ch6 stalls after 3
`endif

        foreach (vecs[i]) run_transfer(vecs[i], 1'b0, -1, $sformatf("vec%0d", i));

        // Reset during channel 4, then a clean transfer.
        run_transfer(vecs[0], 1'b0, 4, "abort");
        run_transfer(vecs[0], 1'b0, -1, "post_abort");

        for (int r = 0; r < 6; r++) begin
            v = mk(-1, 8, -1, 0, -1, $urandom_range(2, 0), -1, -1, 0);
            if ($urandom_range(1, 0) == 1) begin
                v.short_ch = $urandom_range(NUM_CH-1, 0);
                v.ch_len   = $urandom_range(10, 5);
            end
            if ($urandom_range(3, 0) == 0) begin
                v.stray_ch  = $urandom_range(NUM_CH-1, 0);
                v.stray_tgt = (v.stray_ch + 1 + $urandom_range(NUM_CH-2, 0)) % NUM_CH;
            end
            if ($urandom_range(3, 0) == 0) v.dup_ch = $urandom_range(NUM_CH-1, 0);
            run_transfer(v, 1'b1, -1, $sformatf("rand%0d", r));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, total=%0d bad=%0d", total, bad);
        $fatal(1);
    end

endmodule
